prm_edge_scan: RTL and testbench



---
 rtl/prm_scan_pkg.sv | 28 ++
 rtl/prm_result_packer.sv | 61 ++++++
 rtl/prm_edge_scan.sv | 106 ++++++++++
 tb/tb_prm_edge_scan.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prm_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prm_scan_pkg
// Brief   : Shared constants, FSM states and result-word type for the PRM
//           edge-scan sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package prm_scan_pkg;

    localparam int CODE_W = 15;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;
    localparam int IDX_W  = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        PUSH = 2'd2,
        DONE = 2'd3
    } scan_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              last;
    } result_word_t;

endpackage
`default_nettype wire

// File: rtl/prm_result_packer.sv
`default_nettype none
// ============================================================================
// Module  : prm_result_packer
// Brief   : Packs per-code checker results into words and holds each word on
//           a valid/ready interface until it is accepted.
// Revision: 1.0 - initial release
// ============================================================================
module prm_result_packer
    import prm_scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sample,
    input  logic              i_bit,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_close,
    output logic              o_accept,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last
);

    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_shift_next;
    logic [IDX_W-1:0]  r_idx;
    result_word_t      r_word;
    logic              r_valid;

    // The closing word includes the bit sampled in the same cycle.
    assign w_shift_next = r_shift | (WORD_W'(i_bit) << r_idx);
    assign o_close      = i_sample && ((r_idx == IDX_W'(WORD_W - 1)) || i_last);
    assign o_accept     = r_valid && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (o_accept) begin
            r_valid <= 1'b0;
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_sample) begin
            r_shift <= w_shift_next;
            r_idx   <= r_idx + IDX_W'(1);
            if (o_close) begin
                r_word.data <= w_shift_next;
                r_word.last <= i_last;
                r_valid     <= 1'b1;
            end
        end
    end

    assign o_data  = r_word.data;
    assign o_last  = r_word.last;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/prm_edge_scan.sv
`default_nettype none
// ============================================================================
// Module  : prm_edge_scan
// Brief   : Walks a range of edge codes through the obstacle-logic checker and
//           streams packed edge_mask results with a running hit count.
// Revision: 1.0 - initial release
// ============================================================================
module prm_edge_scan
    import prm_scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CODE_W-1:0] code_base,
    input  logic [CNT_W-1:0]  code_count,
    output logic [CODE_W-1:0] chk_code,
    input  logic              chk_mask,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last,
    output logic [CNT_W-1:0]  hit_count,
    output logic              busy,
    output logic              done
);

    scan_state_e       r_state;
    logic [CODE_W-1:0] r_code;
    logic [CNT_W-1:0]  r_rem;
    logic [CNT_W-1:0]  r_hits;
    logic              r_busy;
    logic              r_done;
    logic              w_sample;
    logic              w_final_code;
    logic              w_close;
    logic              w_accept;

    assign w_sample     = (r_state == SCAN);
    assign w_final_code = (r_rem == CNT_W'(1));

    prm_result_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sample (w_sample),
        .i_bit    (chk_mask),
        .i_last   (w_final_code),
        .i_ready  (word_ready),
        .o_close  (w_close),
        .o_accept (w_accept),
        .o_data   (word_data),
        .o_valid  (word_valid),
        .o_last   (word_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_rem   <= '0;
            r_hits  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // busy is still set during the done pulse, so a start
                    // coinciding with done is dropped.
                    r_busy <= 1'b0;
                    if (start && !r_busy) begin
                        r_code  <= code_base;
                        r_rem   <= code_count;
                        r_hits  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (code_count != '0) ? SCAN : DONE;
                    end
                end
                SCAN: begin
                    r_hits <= r_hits + CNT_W'(chk_mask);
                    r_code <= r_code + CODE_W'(1);
                    r_rem  <= r_rem - CNT_W'(1);
                    if (w_close) begin
                        r_state <= PUSH;
                    end
                end
                PUSH: begin
                    if (w_accept) begin
                        r_state <= word_last ? DONE : SCAN;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign chk_code  = r_code;
    assign hit_count = r_hits;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_prm_edge_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_prm_edge_scan
// Brief   : Self-checking bench: table-driven scans, randomized scans against
//           an array-based reference model, and corner-case sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prm_edge_scan;
    import prm_scan_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CODE_W-1:0] code_base;
    logic [CNT_W-1:0]  code_count;
    logic [CODE_W-1:0] chk_code;
    logic              chk_mask;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              word_last;
    logic [CNT_W-1:0]  hit_count;
    logic              busy;
    logic              done;

    int mode  = 0;
    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    prm_edge_scan dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .code_base  (code_base),
        .code_count (code_count),
        .chk_code   (chk_code),
        .chk_mask   (chk_mask),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_last  (word_last),
        .hit_count  (hit_count),
        .busy       (busy),
        .done       (done)
    );

    // Checker stand-in: 0 = code[0], 1 = code<8, 2 = all ones, else a hash.
    function automatic logic ref_mask(input int m, input logic [CODE_W-1:0] c);
        logic [31:0] h;
        h = 32'(c) * 32'd2654435761;
        case (m)
            0:       return c[0];
            1:       return (c < 15'd8);
            2:       return 1'b1;
            default: return h[17];
        endcase
    endfunction

    assign chk_mask = ref_mask(mode, chk_code);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_scan(input logic [CODE_W-1:0] base, input int cnt, input int stall,
                            input bit rnd, input bit mid_start,
                            output logic [31:0] first_w, output logic [31:0] last_w,
                            output int nw);
        logic [31:0]       exp_w[$];
        logic [31:0]       tmp;
        logic [CODE_W-1:0] c;
        logic [31:0]       pd;
        logic              pl;
        logic [CODE_W-1:0] pc;
        int  exp_hits = 0;
        int  nwords;
        int  cyc = 0;
        int  st = 0;
        int  acc_obs = -10;
        bit  held = 0;
        bit  got_done = 0;
        bit  go;
        nwords = (cnt + 31) / 32;
        for (int w = 0; w < nwords; w++) exp_w.push_back(32'h0);
        for (int i = 0; i < cnt; i++) begin
            c = base + CODE_W'(i);
            if (ref_mask(mode, c)) begin
                tmp = exp_w[i / 32];
                tmp[i % 32] = 1'b1;
                exp_w[i / 32] = tmp;
                exp_hits++;
            end
        end
        nw = 0; first_w = 32'h0; last_w = 32'h0;
        pd = 32'h0; pl = 1'b0; pc = '0;
        start = 1'b1; code_base = base; code_count = CNT_W'(cnt); word_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (!got_done && cyc < cnt * 2 + 200) begin
            if (done) begin
                got_done = 1;
                check("done_latency", 64'(cyc), 64'(acc_obs + 1));
            end
            if (mid_start && cyc == 7) begin
                start = 1'b1; code_base = 15'h5555; code_count = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (word_valid) begin
                if (held) begin
                    check("hold_data", 64'(word_data), 64'(pd));
                    check("hold_last", 64'(word_last), 64'(pl));
                    check("hold_code", 64'(chk_code), 64'(pc));
                end
                pd = word_data; pl = word_last; pc = chk_code;
                go = rnd ? 1'($urandom_range(0, 1)) : (st >= stall);
                if (go) begin
                    if (nw < nwords) begin
                        check("word_data", 64'(word_data), 64'(exp_w[nw]));
                        check("word_last", 64'(word_last), 64'(nw == nwords - 1));
                    end else begin
                        check("extra_word", 64'(1), 64'(0));
                    end
                    if (nw == 0) first_w = word_data;
                    last_w = word_data;
                    nw++; st = 0; held = 0;
                    acc_obs = cyc + 1;
                end else begin
                    st++; held = 1;
                end
                word_ready = go;
            end else begin
                word_ready = 1'($urandom_range(0, 1));
                held = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; word_ready = 1'b0;
        check("done_seen", 64'(got_done), 64'(1));
        check("word_count", 64'(nw), 64'(nwords));
        check("hit_count", 64'(hit_count), 64'(exp_hits));
        check("busy_after", 64'(busy), 64'(0));
    endtask

    typedef struct {
        logic [CODE_W-1:0] base;
        int                cnt;
        int                mode;
        int                stall;
        logic [31:0]       first_w;
        logic [31:0]       last_w;
        int                hits;
        int                nwords;
    } vec_t;

    initial begin
        vec_t        tbl[4];
        logic [31:0] fw, lw;
        int          nw;
        int          w;

        tbl[0] = '{15'h0000, 32, 0, 0,  32'hAAAAAAAA, 32'hAAAAAAAA, 16, 1};
        tbl[1] = '{15'h7FF0, 40, 1, 0,  32'h00FF0000, 32'h00000000, 8,  2};
        tbl[2] = '{15'h0000, 5,  2, 0,  32'h0000001F, 32'h0000001F, 5,  1};
        tbl[3] = '{15'h0000, 64, 0, 10, 32'hAAAAAAAA, 32'hAAAAAAAA, 32, 2};

        rst_n = 1'b0; start = 1'b0; code_base = '0; code_count = '0; word_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_code",  64'(chk_code),   64'(0));
        check("rst_valid", 64'(word_valid), 64'(0));
        check("rst_data",  64'(word_data),  64'(0));
        check("rst_busy",  64'(busy),       64'(0));
        check("rst_done",  64'(done),       64'(0));
        check("rst_hits",  64'(hit_count),  64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            run_scan(tbl[i].base, tbl[i].cnt, tbl[i].stall, 1'b0, 1'b0, fw, lw, nw);
            check("tbl_first", 64'(fw), 64'(tbl[i].first_w));
            check("tbl_last",  64'(lw), 64'(tbl[i].last_w));
            check("tbl_nw",    64'(nw), 64'(tbl[i].nwords));
            check("tbl_hits",  64'(hit_count), 64'(tbl[i].hits));
        end

        // Zero count: no word, done two cycles after start; a start during
        // the done pulse must be ignored.
        start = 1'b1; code_base = 15'h0010; code_count = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("z_busy1",  64'(busy),       64'(1));
        check("z_done1",  64'(done),       64'(0));
        check("z_valid1", 64'(word_valid), 64'(0));
        @(posedge clk); #1;
        check("z_busy2",  64'(busy),       64'(1));
        check("z_done2",  64'(done),       64'(1));
        start = 1'b1; code_count = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("z_busy3",  64'(busy),       64'(0));
        check("z_done3",  64'(done),       64'(0));
        check("z_valid3", 64'(word_valid), 64'(0));

        // Randomized scans, including one with a start pulsed mid-scan.
        mode = 3;
        for (int i = 0; i < 6; i++) begin
            run_scan(CODE_W'($urandom), (i == 0) ? 100 : int'($urandom_range(1, 100)),
                     0, 1'b1, (i == 0), fw, lw, nw);
        end

        // Asynchronous reset while a word is held in PUSH.
        start = 1'b1; code_base = 15'h0100; code_count = 16'd64; word_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!word_valid && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("pre_rst_valid", 64'(word_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_code",  64'(chk_code),   64'(0));
        check("arst_valid", 64'(word_valid), 64'(0));
        check("arst_data",  64'(word_data),  64'(0));
        check("arst_last",  64'(word_last),  64'(0));
        check("arst_hits",  64'(hit_count),  64'(0));
        check("arst_busy",  64'(busy),       64'(0));
        check("arst_done",  64'(done),       64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_scan(15'h0123, 40, 2, 1'b0, 1'b0, fw, lw, nw);

        // Full code range: 1024 words, final one full.
        run_scan(CODE_W'($urandom), 32768, 0, 1'b0, 1'b0, fw, lw, nw);
        check("full_nw", 64'(nw), 64'(1024));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
